key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Input-side counterpart to the board LED drivers: conditions raw push-button inputs (keyB etc.) into clean events.
//   Per key: 2-FF synchroniser, debounce FSM, then a level output plus one-cycle press, release and long-press pulses.
//   Sits between board key pins and user logic such as LED pattern controllers; keys are fully independent.
// PARAMETERS
//   KEY_NUM      4            number of keys handled (1..8)
//   ACTIVE_LOW   1            1: pin low = pressed; 0: pin high = pressed
//   CNT_W        25           width of debounce and hold counters
//   DEBOUNCE_CYC 240_000      cycles input must be stable to accept a change (10 ms @ 24 MHz); >=2
//   LONG_CYC     24_000_000   cycles in HELD before key_long fires (1 s @ 24 MHz); >DEBOUNCE_CYC, <2**CNT_W
// PORTS
//   CLK_IN       in   1        system clock
//   RST_N        in   1        asynchronous reset, active low
//   key_in       in   KEY_NUM  raw asynchronous key pins
//   key_level    out  KEY_NUM  debounced state, 1 = pressed
//   key_press    out  KEY_NUM  1-cycle pulse on accepted press
//   key_release  out  KEY_NUM  1-cycle pulse on accepted release
//   key_long     out  KEY_NUM  1-cycle pulse, once per press, after LONG_CYC cycles in HELD
// BEHAVIOUR
//   Reset (RST_N=0, async, any time incl. mid-debounce): all outputs 0, all FSMs IDLE, counters 0.
//     Synchroniser flops reset to the released level (ACTIVE_LOW ? 1 : 0), so no press event follows reset.
//   p[i] = synchronised key_in[i], inverted when ACTIVE_LOW=1; 1 = pressed.
//   Per-key FSM, registered outputs, state moves on posedge CLK_IN:
//     IDLE:     p=1 -> DEB_DOWN, deb_cnt<=0.
//     DEB_DOWN: p=0 -> IDLE (bounce rejected, no event).
//               p=1, deb_cnt!=DEBOUNCE_CYC-1 -> deb_cnt+1.
//               p=1, deb_cnt==DEBOUNCE_CYC-1 -> HELD; key_level<=1, key_press<=1 for 1 cycle, hold_cnt<=0.
//     HELD:     hold_cnt increments each cycle and saturates at LONG_CYC (no wrap).
//               On hold_cnt==LONG_CYC-1: key_long<=1 for 1 cycle; fires at most once per press.
//               p=0 -> DEB_UP, deb_cnt<=0.
//     DEB_UP:   hold_cnt frozen.
//               p=1 -> HELD (glitch rejected; hold_cnt resumes, not cleared).
//               p=0, deb_cnt==DEBOUNCE_CYC-1 -> IDLE; key_level<=0, key_release<=1 for 1 cycle.
//   Latency: a clean edge on key_in is sampled at clock edge E.
//     The press/release pulse and the key_level change are visible after edge E+2+DEBOUNCE_CYC.
//     Input pulses shorter than DEBOUNCE_CYC cycles produce no event.
//   key_press and key_release never both assert in one cycle for the same key.
//     key_long never coincides with key_release.
//   Different keys may emit events in the same cycle; there is no arbitration.
//   Counter compare is exact equality at CNT_W bits; parameters violating their limits are unsupported.
// TESTING  (DEBOUNCE_CYC=8, LONG_CYC=40, KEY_NUM=2, ACTIVE_LOW=1)
//   1) Reset then idle pins high for 100 cycles -> all outputs stay 0; no pulse at reset release.
//   2) key_in[0] low at edge E, held 20 cycles
//      -> key_press[0] high exactly 1 cycle after edge E+10; key_level[0]=1 from then on.
//   3) key_in[0] bounces low 5 / high 3 / low 4 cycles, then high -> no key_press, key_level stays 0.
//   4) Hold key_in[0] low 60 cycles
//      -> key_press, then key_long 40 cycles later (1 pulse only).
//      Release -> key_release 10 cycles after the rising edge, key_level 0.
//   5) While HELD, a 3-cycle high glitch on key_in[1]
//      -> no key_release; hold_cnt resumes.
//      Both keys pressed at the same edge -> key_press=2'b11 in one cycle.
//   6) Assert RST_N=0 mid-DEB_DOWN and mid-HELD
//      -> outputs clear immediately (asynchronously).
//      Key still held at reset release -> a new key_press follows 10 cycles later.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: per key a 2-FF synchroniser, a debounce FSM,
// a debounced level and one-cycle press / release / long-press pulses.
// Keys are fully independent; events on different keys may coincide.
module key_debounce #(
    parameter int KEY_NUM      = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int CNT_W        = 25,
    parameter int DEBOUNCE_CYC = 240_000,
    parameter int LONG_CYC     = 24_000_000
) (
    input  logic               CLK_IN,
    input  logic               RST_N,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]   LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0]   LONG_MAX  = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    // Pin level that means "released"; synchroniser resets here so reset
    // release never looks like a press.
    localparam logic [KEY_NUM-1:0] REL_LVL   = (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}}
                                                                 : {KEY_NUM{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB_DOWN,
        ST_HELD,
        ST_DEB_UP
    } state_t;

    logic [KEY_NUM-1:0] r_sync1;
    logic [KEY_NUM-1:0] r_sync2;
    logic [KEY_NUM-1:0] w_pressed;

    // Two-flop synchroniser for the asynchronous key pins.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= REL_LVL;
            r_sync2 <= REL_LVL;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity: 1 = pressed.
    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    genvar g;
    generate
        for (g = 0; g < KEY_NUM; g++) begin : g_key
            state_t           r_state;
            logic [CNT_W-1:0] r_deb_cnt;
            logic [CNT_W-1:0] r_hold_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             r_long;

            // Debounce FSM with registered level and single-cycle event pulses.
            always_ff @(posedge CLK_IN or negedge RST_N) begin
                if (!RST_N) begin
                    r_state    <= ST_IDLE;
                    r_deb_cnt  <= '0;
                    r_hold_cnt <= '0;
                    r_level    <= 1'b0;
                    r_press    <= 1'b0;
                    r_release  <= 1'b0;
                    r_long     <= 1'b0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_pressed[g]) begin
                                r_state   <= ST_DEB_DOWN;
                                r_deb_cnt <= '0;
                            end
                        end
                        ST_DEB_DOWN: begin
                            if (!w_pressed[g]) begin
                                r_state <= ST_IDLE;
                            end else if (r_deb_cnt == DEB_LAST) begin
                                r_state    <= ST_HELD;
                                r_level    <= 1'b1;
                                r_press    <= 1'b1;
                                r_hold_cnt <= '0;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + CNT_ONE;
                            end
                        end
                        ST_HELD: begin
                            // Saturating hold counter makes key_long fire once per press.
                            if (r_hold_cnt != LONG_MAX) begin
                                r_hold_cnt <= r_hold_cnt + CNT_ONE;
                            end
                            if (r_hold_cnt == LONG_LAST) begin
                                r_long <= 1'b1;
                            end
                            if (!w_pressed[g]) begin
                                r_state   <= ST_DEB_UP;
                                r_deb_cnt <= '0;
                            end
                        end
                        ST_DEB_UP: begin
                            // Hold count is frozen here so a rejected glitch resumes it.
                            if (w_pressed[g]) begin
                                r_state <= ST_HELD;
                            end else if (r_deb_cnt == DEB_LAST) begin
                                r_state   <= ST_IDLE;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign key_level[g]   = r_level;
            assign key_press[g]   = r_press;
            assign key_release[g] = r_release;
            assign key_long[g]    = r_long;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short debounce/long-press times, two keys,
// active-low pins.
module tb_key_debounce;

    localparam int KN = 2;

    logic          CLK_IN;
    logic          RST_N;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_level;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;

    int n_checks = 0;
    int n_errors = 0;

    int cnt_press [KN];
    int cnt_rel   [KN];
    int cnt_long  [KN];

    key_debounce #(
        .KEY_NUM      (KN),
        .ACTIVE_LOW   (1),
        .CNT_W        (25),
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (40)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RST_N       (RST_N),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    // Pulse tally, sampled mid-cycle while out of reset.
    initial begin
        for (int k = 0; k < KN; k++) begin
            cnt_press[k] = 0;
            cnt_rel[k]   = 0;
            cnt_long[k]  = 0;
        end
    end
    always @(negedge CLK_IN) begin
        if (RST_N) begin
            for (int k = 0; k < KN; k++) begin
                if (key_press[k])   cnt_press[k]++;
                if (key_release[k]) cnt_rel[k]++;
                if (key_long[k])    cnt_long[k]++;
            end
        end
    end

    typedef struct {
        logic [KN-1:0] kin;
        int            cyc;
        logic [KN-1:0] lvl;
        logic [KN-1:0] prs;
        logic [KN-1:0] rel;
        logic [KN-1:0] lng;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [KN-1:0] lvl, input logic [KN-1:0] prs,
                           input logic [KN-1:0] rel, input logic [KN-1:0] lng);
        chk({nm, ".level"},   int'(key_level),   int'(lvl));
        chk({nm, ".press"},   int'(key_press),   int'(prs));
        chk({nm, ".release"}, int'(key_release), int'(rel));
        chk({nm, ".long"},    int'(key_long),    int'(lng));
    endtask

    initial begin
        // Tests 1-4 on key 0: idle, clean press, bounce rejection, long press.
        tbl.push_back('{2'b11, 100, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,  10, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   1, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   1, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   8, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,  10, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,   1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{2'b11,   1, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   5, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,   3, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   4, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,  20, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,  10, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   1, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b10,  39, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   1, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back('{2'b10,   1, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b10,   9, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,  10, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b11,   1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{2'b11,   1, 2'b00, 2'b00, 2'b00, 2'b00});

        RST_N  = 1'b0;
        key_in = 2'b11;
        step(3);
        chk_out("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            key_in = tbl[i].kin;
            step(tbl[i].cyc);
            chk_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng);
        end
        chk("cnt_press0_t4", cnt_press[0], 2);
        chk("cnt_rel0_t4",   cnt_rel[0],   2);
        chk("cnt_long0_t4",  cnt_long[0],  1);
        chk("cnt_press1_t4", cnt_press[1], 0);

        // Test 5: key 1 held, 3-cycle glitch rejected, hold count resumes.
        key_in = 2'b01;
        step(11);
        chk_out("t5_press1", 2'b10, 2'b10, 2'b00, 2'b00);
        key_in = 2'b11;
        step(3);
        key_in = 2'b01;
        step(39);
        chk_out("t5_glitch", 2'b10, 2'b00, 2'b00, 2'b00);
        chk("t5_no_rel1", cnt_rel[1], 0);
        step(1);
        chk_out("t5_long1", 2'b10, 2'b00, 2'b00, 2'b10);
        step(1);
        chk_out("t5_long1_end", 2'b10, 2'b00, 2'b00, 2'b00);
        key_in = 2'b11;
        step(11);
        chk_out("t5_rel1", 2'b00, 2'b00, 2'b10, 2'b00);
        step(2);
        key_in = 2'b00;
        step(10);
        chk_out("t5_both_pre", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        chk_out("t5_both_press", 2'b11, 2'b11, 2'b00, 2'b00);
        key_in = 2'b11;
        step(10);
        chk_out("t5_both_pre_rel", 2'b11, 2'b00, 2'b00, 2'b00);
        step(1);
        chk_out("t5_both_rel", 2'b00, 2'b00, 2'b11, 2'b00);
        step(2);
        chk("cnt_press0_t5", cnt_press[0], 3);
        chk("cnt_press1_t5", cnt_press[1], 2);
        chk("cnt_rel1_t5",   cnt_rel[1],   2);
        chk("cnt_long1_t5",  cnt_long[1],  1);
        chk("cnt_long0_t5",  cnt_long[0],  1);

        // Test 6a: asynchronous reset while the press pulse is high (HELD).
        key_in = 2'b10;
        step(11);
        chk_out("t6_press", 2'b01, 2'b01, 2'b00, 2'b00);
        #2;
        RST_N = 1'b0;
        #1;
        chk_out("t6_async_clr", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2);
        RST_N = 1'b1;
        step(10);
        chk_out("t6_rearm_pre", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        chk_out("t6_rearm_press", 2'b01, 2'b01, 2'b00, 2'b00);

        // Test 6b: reset mid-debounce, key still held afterwards.
        key_in = 2'b11;
        step(12);
        chk_out("t6_idle", 2'b00, 2'b00, 2'b00, 2'b00);
        key_in = 2'b10;
        step(6);
        #2;
        RST_N = 1'b0;
        #1;
        chk_out("t6_deb_clr", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2);
        RST_N = 1'b1;
        step(10);
        chk_out("t6_deb_pre", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        chk_out("t6_deb_press", 2'b01, 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
